// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle shared by the CPU requester, the host loader/debug requester,
// the data-memory port arbiter and the data RAM.
interface dmem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int CW = 16
);
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          host_req;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_lock;
  logic          host_ack;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] cpu_cnt;
  logic [CW-1:0] host_cnt;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  host_req, host_wr, host_addr, host_wdata, host_lock,
    input  mem_rdata,
    output cpu_ack, host_ack, rdata,
    output mem_en, mem_wr, mem_addr, mem_wdata,
    output cpu_cnt, host_cnt
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output host_req, host_wr, host_addr, host_wdata, host_lock,
    output mem_rdata,
    input  cpu_ack, host_ack, rdata,
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    input  cpu_cnt, host_cnt
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU datapath
// and the host loader, with host lock and saturating per-requester counters.
module dmem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  dmem_port_arbiter_if.slave   bus,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE_C = 3'd1;
  localparam logic [2:0] ISSUE_H = 3'd2;
  localparam logic [2:0] ACK_C   = 3'd3;
  localparam logic [2:0] ACK_H   = 3'd4;

  // Handshake: a requester raises x_req with a stable command and holds it
  // until the single-cycle x_ack; the command is captured when granted.
  logic [2:0]    state, state_d;
  logic          last_host;
  logic          cpu_elig, host_elig;
  logic          load_cpu, load_host;
  logic          mem_en_q, mem_wr_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [CW-1:0] cpu_cnt_q, host_cnt_q;

  assign cpu_elig  = bus.cpu_req & ~bus.host_lock;
  assign host_elig = bus.host_req;

  always_comb begin
    state_d   = state;
    load_cpu  = 1'b0;
    load_host = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_elig && (!host_elig || last_host)) begin
          load_cpu = 1'b1;
          state_d  = ISSUE_C;
        end else if (host_elig) begin
          load_host = 1'b1;
          state_d   = ISSUE_H;
        end
      end
      ISSUE_C: state_d = ACK_C;
      ISSUE_H: state_d = ACK_H;
      // The requester just served still has req high here, so only the
      // other side may be granted straight from an ACK state.
      ACK_C: begin
        if (host_elig) begin
          load_host = 1'b1;
          state_d   = ISSUE_H;
        end else begin
          state_d = IDLE;
        end
      end
      ACK_H: begin
        if (cpu_elig) begin
          load_cpu = 1'b1;
          state_d  = ISSUE_C;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      last_host   <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_cnt_q   <= '0;
      host_cnt_q  <= '0;
    end else begin
      state    <= state_d;
      mem_en_q <= load_cpu | load_host;
      if (load_cpu) begin
        mem_wr_q    <= bus.cpu_wr;
        mem_addr_q  <= bus.cpu_addr;
        mem_wdata_q <= bus.cpu_wdata;
      end else if (load_host) begin
        mem_wr_q    <= bus.host_wr;
        mem_addr_q  <= bus.host_addr;
        mem_wdata_q <= bus.host_wdata;
      end
      if (state == ACK_C) begin
        last_host <= 1'b0;
        if (cpu_cnt_q != {CW{1'b1}}) cpu_cnt_q <= cpu_cnt_q + CW'(1);
      end
      if (state == ACK_H) begin
        last_host <= 1'b1;
        if (host_cnt_q != {CW{1'b1}}) host_cnt_q <= host_cnt_q + CW'(1);
      end
    end
  end

  assign bus.cpu_ack   = (state == ACK_C);
  assign bus.host_ack  = (state == ACK_H);
  assign bus.rdata     = (bus.cpu_ack | bus.host_ack) ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_cnt   = cpu_cnt_q;
  assign bus.host_cnt  = host_cnt_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: vector table, round-robin, lock,
// reset-abort and counter saturation sequences against a scoreboard.
module tb_dmem_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int CW = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] dbg_state;

  dmem_port_arbiter_if #(.AW(AW), .DW(DW), .CW(CW)) bus ();

  dmem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 Clk = ~Clk;

  // Read-first RAM model: data appears the cycle after mem_en.
  logic [DW-1:0] ram [256];
  always @(posedge Clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          chk;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t cpu_q[$];
  exp_t host_q[$];

  typedef struct packed {
    logic          h;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic [CW-1:0] exp_cpu_cnt;
    logic [CW-1:0] exp_host_cnt;
  } vec_t;

  vec_t vecs[8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard side: capture the issued command, compare on each ack.
  logic          iss_wr;
  logic [AW-1:0] iss_addr;
  logic [DW-1:0] iss_wdata;
  logic          prev_en = 1'b0;

  task automatic pop_and_check(input logic h);
    exp_t e;
    if (h ? (host_q.size() == 0) : (cpu_q.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_unexpected: got %s ack with empty queue at %0t", h ? "host" : "cpu", $time);
    end else begin
      e = h ? host_q.pop_front() : cpu_q.pop_front();
      check(h ? "host_cmd" : "cpu_cmd", {7'd0, iss_wr, iss_addr, iss_wdata}, {7'd0, e.wr, e.addr, e.wdata});
      if (e.chk) check(h ? "host_rdata" : "cpu_rdata", 32'(bus.rdata), 32'(e.rdata));
    end
  endtask

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.mem_en) begin
        check("mem_en_single", 32'(prev_en), 32'd0);
        iss_wr    = bus.mem_wr;
        iss_addr  = bus.mem_addr;
        iss_wdata = bus.mem_wdata;
      end
      if (bus.cpu_ack)  pop_and_check(1'b0);
      if (bus.host_ack) pop_and_check(1'b1);
    end
    prev_en = bus.mem_en;
  end

  task automatic push_exp(input logic h, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic chk, input logic [DW-1:0] rd);
    exp_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.chk = chk; e.rdata = rd;
    if (h) host_q.push_back(e);
    else   cpu_q.push_back(e);
  endtask

  task automatic set_cmd(input logic h, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (h) begin
      bus.host_req = 1'b1; bus.host_wr = wr; bus.host_addr = a; bus.host_wdata = d;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Single uncontended access starting from IDLE; checks the 2-cycle latency.
  task automatic do_access(input logic h, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] rd);
    push_exp(h, wr, a, d, !wr, rd);
    set_cmd(h, wr, a, d);
    @(negedge Clk);
    check("lat_mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge Clk);
    check("lat_ack", 32'(h ? bus.host_ack : bus.cpu_ack), 32'd1);
    if (h) bus.host_req = 1'b0;
    else   bus.cpu_req  = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h10, 16'h1234, 16'h0000, 8'd1, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 8'h20, 16'hBEEF, 16'h0000, 8'd1, 8'd1};
    vecs[2] = '{1'b1, 1'b0, 8'h20, 16'h0000, 16'hBEEF, 8'd1, 8'd2};
    vecs[3] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h1234, 8'd2, 8'd2};
    vecs[4] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'hBEEF, 8'd3, 8'd2};
    vecs[5] = '{1'b1, 1'b0, 8'h10, 16'h0000, 16'h1234, 8'd3, 8'd3};
    vecs[6] = '{1'b1, 1'b1, 8'h10, 16'h5555, 16'h0000, 8'd3, 8'd4};
    vecs[7] = '{1'b0, 1'b0, 8'h10, 16'h0000, 16'h5555, 8'd4, 8'd4};

    Reset = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_lock = 1'b0;
    repeat (3) @(negedge Clk);

    check("rst_cpu_ack",   32'(bus.cpu_ack), 32'd0);
    check("rst_host_ack",  32'(bus.host_ack), 32'd0);
    check("rst_rdata",     32'(bus.rdata), 32'd0);
    check("rst_mem_en",    32'(bus.mem_en), 32'd0);
    check("rst_mem_wr",    32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_cpu_cnt",   32'(bus.cpu_cnt), 32'd0);
    check("rst_host_cnt",  32'(bus.host_cnt), 32'd0);
    check("rst_state",     32'(dbg_state), 32'd0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].h, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      check("vec_cpu_cnt",  32'(bus.cpu_cnt),  32'(vecs[i].exp_cpu_cnt));
      check("vec_host_cnt", 32'(bus.host_cnt), 32'(vecs[i].exp_host_cnt));
    end

    // Both requesters held from reset: C first (last=HOST), then alternate.
    Reset = 1'b1;
    set_cmd(1'b0, 1'b1, 8'h30, 16'hAAAA);
    set_cmd(1'b1, 1'b1, 8'h31, 16'h5555);
    repeat (2) push_exp(1'b0, 1'b1, 8'h30, 16'hAAAA, 1'b0, 16'h0);
    repeat (2) push_exp(1'b1, 1'b1, 8'h31, 16'h5555, 1'b0, 16'h0);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      check("rr_mem_en",   32'(bus.mem_en),   32'(i % 2 == 1));
      check("rr_cpu_ack",  32'(bus.cpu_ack),  32'(i == 2 || i == 6));
      check("rr_host_ack", 32'(bus.host_ack), 32'(i == 4 || i == 8));
    end
    bus.cpu_req = 1'b0;
    bus.host_req = 1'b0;
    @(negedge Clk);
    check("rr_cpu_cnt",  32'(bus.cpu_cnt),  32'd2);
    check("rr_host_cnt", 32'(bus.host_cnt), 32'd2);

    // Host lock: only host served (3 cycles each), CPU next once lock drops.
    bus.host_lock = 1'b1;
    set_cmd(1'b0, 1'b1, 8'h40, 16'h1111);
    set_cmd(1'b1, 1'b1, 8'h41, 16'h2222);
    repeat (3) push_exp(1'b1, 1'b1, 8'h41, 16'h2222, 1'b0, 16'h0);
    push_exp(1'b0, 1'b1, 8'h40, 16'h1111, 1'b0, 16'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clk);
      check("lock_cpu_ack",  32'(bus.cpu_ack),  32'd0);
      check("lock_host_ack", 32'(bus.host_ack), 32'(i % 3 == 2));
    end
    bus.host_lock = 1'b0;
    bus.host_req = 1'b0;
    @(negedge Clk);
    check("unlock_mem_en", 32'(bus.mem_en), 32'd1);
    @(negedge Clk);
    check("unlock_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    @(negedge Clk);
    check("lock_cpu_cnt",  32'(bus.cpu_cnt),  32'd3);
    check("lock_host_cnt", 32'(bus.host_cnt), 32'd5);

    // Reset during ISSUE aborts the access with no ack.
    set_cmd(1'b0, 1'b1, 8'h50, 16'h7777);
    @(negedge Clk);
    check("abort_issue_en", 32'(bus.mem_en), 32'd1);
    Reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(negedge Clk);
    check("abort_mem_en",   32'(bus.mem_en),   32'd0);
    check("abort_cpu_ack",  32'(bus.cpu_ack),  32'd0);
    check("abort_cpu_cnt",  32'(bus.cpu_cnt),  32'd0);
    check("abort_host_cnt", 32'(bus.host_cnt), 32'd0);
    check("abort_state",    32'(dbg_state),    32'd0);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("abort_no_ack", 32'({bus.cpu_ack, bus.host_ack}), 32'd0);
    end

    // Saturation of the CPU counter at all-ones after 2^CW+1 accesses.
    for (int i = 1; i <= (1 << CW) + 1; i++) begin
      do_access(1'b0, 1'b1, 8'($urandom_range(8'h80, 8'hFF)), 16'($urandom_range(0, 16'hFFFF)), 16'h0);
      if (i == (1 << CW) - 2) check("sat_cnt_below", 32'(bus.cpu_cnt), 32'((1 << CW) - 2));
      if (i == (1 << CW) - 1) check("sat_cnt_reach", 32'(bus.cpu_cnt), 32'((1 << CW) - 1));
    end
    check("sat_cnt_hold",  32'(bus.cpu_cnt),  32'((1 << CW) - 1));
    check("sat_host_cnt",  32'(bus.host_cnt), 32'd0);

    check("cpu_q_empty",  32'(cpu_q.size()),  32'd0);
    check("host_q_empty", 32'(host_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
